// File: rtl/ascon_serial_io.sv
// ascon_serial_io: converts bit-serial masked inputs into parallel share buffers for an
// ASCON core, and streams the core's ciphertext and tag back out bit-serially.
//
// Parameters:
//   K      key length in bits (64..160)
//   L      associated-data length in bits (>=2)
//   Y      plaintext/ciphertext length in bits (>=2)
//   SHARES Boolean shares per input field (1..4)
//
// Ports:
//   clk, rst (async active-low)
//   key_si/nonce_si/ad_si/pt_si  serial share bits, accepted on in_valid && in_ready
//   start_i, key_reload_i        start request, forced key reload
//   key_o/nonce_o/ad_o/pt_o      parallel shares, share s at [s*W +: W]
//   core_start, core_done_i      core handshake
//   ct_i, tag_i                  core results
//   ct_so/tag_so, ct_valid/tag_valid, out_ready  serial result stream, LSB first
//   busy                         high whenever not loading
//
// Build option: define ASCON_IO_KEY_RETAIN_EN to keep the key across operations.
module ascon_serial_io #(
    parameter int unsigned K      = 128,
    parameter int unsigned L      = 32,
    parameter int unsigned Y      = 32,
    parameter int unsigned SHARES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SHARES-1:0]     key_si,
    input  logic [SHARES-1:0]     nonce_si,
    input  logic [SHARES-1:0]     ad_si,
    input  logic [SHARES-1:0]     pt_si,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  start_i,
    input  logic                  key_reload_i,
    output logic [SHARES*K-1:0]   key_o,
    output logic [SHARES*128-1:0] nonce_o,
    output logic [SHARES*L-1:0]   ad_o,
    output logic [SHARES*Y-1:0]   pt_o,
    output logic                  core_start,
    input  logic                  core_done_i,
    input  logic [Y-1:0]          ct_i,
    input  logic [127:0]          tag_i,
    output logic                  ct_so,
    output logic                  tag_so,
    output logic                  ct_valid,
    output logic                  tag_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int unsigned NW  = 128;
    localparam int unsigned M01 = (K > NW) ? K : NW;
    localparam int unsigned M02 = (M01 > L) ? M01 : L;
    localparam int unsigned M   = (M02 > Y) ? M02 : Y;
    localparam int unsigned N   = (Y > NW) ? Y : NW;
    localparam int unsigned LCW = $clog2(M + 1);
    localparam int unsigned UCW = $clog2(N);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_BUSY   = 2'd2,
        ST_UNLOAD = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [LCW-1:0]         load_cnt_q;
    logic [UCW-1:0]         unload_cnt_q;
    logic [SHARES*K-1:0]    key_q;
    logic [SHARES*NW-1:0]   nonce_q;
    logic [SHARES*L-1:0]    ad_q;
    logic [SHARES*Y-1:0]    pt_q;
    logic [Y-1:0]           ct_sh_q;
    logic [NW-1:0]          tag_sh_q;

    logic in_ready_q, busy_q, core_start_q, ct_valid_q, tag_valid_q;
    logic core_start_d, ct_valid_d, tag_valid_d;
    logic accept, capture, advance, finish, key_shift, key_hold;

`ifdef ASCON_IO_KEY_RETAIN_EN
    logic key_valid_q;
    logic reload_on_entry_q;

    // Key lanes freeze only when a retained key exists and no reload was asked for at LOAD entry.
    assign key_hold = key_valid_q && !reload_on_entry_q;
`else
    logic unused_key_reload;

    assign unused_key_reload = key_reload_i;
    assign key_hold          = 1'b0;
`endif

    // State register and registered control outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_LOAD;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            core_start_q <= 1'b0;
            ct_valid_q   <= 1'b0;
            tag_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= (state_d == ST_LOAD);
            busy_q       <= (state_d != ST_LOAD);
            core_start_q <= core_start_d;
            ct_valid_q   <= ct_valid_d;
            tag_valid_q  <= tag_valid_d;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        capture      = 1'b0;
        advance      = 1'b0;
        finish       = 1'b0;
        core_start_d = 1'b0;
        ct_valid_d   = ct_valid_q;
        tag_valid_d  = tag_valid_q;
        key_shift    = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (load_cnt_q == LCW'(M - 1)) state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (start_i) begin
                    core_start_d = 1'b1;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (core_done_i) begin
                    capture = 1'b1;
                    state_d = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                if (out_ready) begin
                    advance = 1'b1;
                    if (unload_cnt_q == UCW'(N - 1)) begin
                        finish  = 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase

        // Valid flags track the index the stream will present after this edge.
        if (capture) begin
            ct_valid_d  = 1'b1;
            tag_valid_d = 1'b1;
        end
        if (advance) begin
            ct_valid_d  = (32'(unload_cnt_q) + 32'd1) < 32'(Y);
            tag_valid_d = (32'(unload_cnt_q) + 32'd1) < 32'(NW);
        end
        if (finish) begin
            ct_valid_d  = 1'b0;
            tag_valid_d = 1'b0;
        end

        key_shift = accept && (load_cnt_q < LCW'(K)) && !key_hold;
    end

    // Serial-to-parallel share loading; a field stops shifting once full
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_cnt_q <= '0;
            key_q      <= '0;
            nonce_q    <= '0;
            ad_q       <= '0;
            pt_q       <= '0;
`ifdef ASCON_IO_KEY_RETAIN_EN
            key_valid_q       <= 1'b0;
            reload_on_entry_q <= 1'b0;
`endif
        end else if (finish) begin
            load_cnt_q <= '0;
            nonce_q    <= '0;
            ad_q       <= '0;
            pt_q       <= '0;
`ifdef ASCON_IO_KEY_RETAIN_EN
            key_valid_q       <= 1'b1;
            reload_on_entry_q <= key_reload_i;
`else
            key_q      <= '0;
`endif
        end else if (accept) begin
            load_cnt_q <= load_cnt_q + LCW'(1);
            for (int s = 0; s < int'(SHARES); s++) begin
                if (key_shift)
                    key_q[s*K +: K] <= {key_q[s*K +: K-1], key_si[s]};
                if (load_cnt_q < LCW'(NW))
                    nonce_q[s*NW +: NW] <= {nonce_q[s*NW +: NW-1], nonce_si[s]};
                if (load_cnt_q < LCW'(L))
                    ad_q[s*L +: L] <= {ad_q[s*L +: L-1], ad_si[s]};
                if (load_cnt_q < LCW'(Y))
                    pt_q[s*Y +: Y] <= {pt_q[s*Y +: Y-1], pt_si[s]};
            end
        end
    end

    // Result capture and LSB-first unload; bit 0 of each shifter is the live output bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ct_sh_q      <= '0;
            tag_sh_q     <= '0;
            unload_cnt_q <= '0;
        end else if (capture) begin
            ct_sh_q      <= ct_i;
            tag_sh_q     <= tag_i;
            unload_cnt_q <= '0;
        end else if (finish) begin
            ct_sh_q      <= '0;
            tag_sh_q     <= '0;
            unload_cnt_q <= '0;
        end else if (advance) begin
            ct_sh_q      <= ct_sh_q >> 1;
            tag_sh_q     <= tag_sh_q >> 1;
            unload_cnt_q <= unload_cnt_q + UCW'(1);
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign core_start = core_start_q;
    assign ct_valid   = ct_valid_q;
    assign tag_valid  = tag_valid_q;
    assign ct_so      = ct_sh_q[0];
    assign tag_so     = tag_sh_q[0];
    assign key_o      = key_q;
    assign nonce_o    = nonce_q;
    assign ad_o       = ad_q;
    assign pt_o       = pt_q;

endmodule
